// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - command bytes and FSM state encoding for prog_loader
package prog_loader_pkg;

  localparam logic [7:0] CMD_I = 8'h49;
  localparam logic [7:0] CMD_D = 8'h44;
  localparam logic [7:0] CMD_G = 8'h47;
  localparam logic [7:0] CMD_H = 8'h48;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_CSUM  = 3'd4,
    S_RUN   = 3'd5
  } state_t;

endpackage

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - framed byte-stream loader into imem/dmem with core go/halt control
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic              mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  output logic              core_rst,
  output logic              done,
  output logic              err
);

  state_t              r_state;
  logic [1:0]          r_hdr_cnt;
  logic [1:0]          r_byte_cnt;
  logic [7:0]          r_lo;
  logic [15:0]         r_cnt;
  logic [23:0]         r_word;
  logic [7:0]          r_csum;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic                r_sel;
  logic                r_we;
  logic                r_core_rst;
  logic                r_done;
  logic                r_err;

  logic                w_fire;
  logic [15:0]         w_hdr16;

  // The only state that stalls the host is the memory write handshake.
  assign rx_ready  = (r_state != S_WRITE);
  assign w_fire    = rx_valid && rx_ready;
  assign w_hdr16   = {rx_data, r_lo};

  assign mem_we    = r_we;
  assign mem_sel   = r_sel;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign core_rst  = r_core_rst;
  assign done      = r_done;
  assign err       = r_err;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_hdr_cnt  <= 2'd0;
      r_byte_cnt <= 2'd0;
      r_lo       <= 8'd0;
      r_cnt      <= 16'd0;
      r_word     <= 24'd0;
      r_csum     <= 8'd0;
      r_addr     <= '0;
      r_wdata    <= 32'd0;
      r_sel      <= 1'b0;
      r_we       <= 1'b0;
      r_core_rst <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_fire) begin
            case (rx_data)
              CMD_I, CMD_D: begin
                r_sel     <= (rx_data == CMD_D);
                r_csum    <= 8'd0;
                r_hdr_cnt <= 2'd0;
                r_state   <= S_HDR;
              end
              CMD_G: begin
                if (!r_err) begin
                  r_core_rst <= 1'b0;
                  r_done     <= 1'b1;
                  r_state    <= S_RUN;
                end
              end
              CMD_H: ;
              default: r_err <= 1'b1;
            endcase
          end
        end

        S_HDR: begin
          if (w_fire) begin
            r_csum    <= r_csum + rx_data;
            r_hdr_cnt <= r_hdr_cnt + 2'd1;
            case (r_hdr_cnt)
              2'd0, 2'd2: r_lo <= rx_data;
              2'd1:       r_addr <= ADDR_W'(w_hdr16);
              default: begin
                r_cnt      <= w_hdr16;
                r_byte_cnt <= 2'd0;
                r_state    <= (w_hdr16 == 16'd0) ? S_CSUM : S_DATA;
              end
            endcase
          end
        end

        S_DATA: begin
          if (w_fire) begin
            r_csum     <= r_csum + rx_data;
            r_byte_cnt <= r_byte_cnt + 2'd1;
            case (r_byte_cnt)
              2'd0: r_word[7:0]   <= rx_data;
              2'd1: r_word[15:8]  <= rx_data;
              2'd2: r_word[23:16] <= rx_data;
              default: begin
                r_wdata <= {rx_data, r_word};
                r_we    <= 1'b1;
                r_state <= S_WRITE;
              end
            endcase
          end
        end

        S_WRITE: begin
          if (mem_ready) begin
            r_we    <= 1'b0;
            r_addr  <= r_addr + 1'b1;
            r_cnt   <= r_cnt - 16'd1;
            r_state <= (r_cnt == 16'd1) ? S_CSUM : S_DATA;
          end
        end

        S_CSUM: begin
          if (w_fire) begin
            if (rx_data != r_csum) r_err <= 1'b1;
            r_state <= S_IDLE;
          end
        end

        S_RUN: begin
          if (w_fire && rx_data == CMD_H) begin
            r_core_rst <= 1'b1;
            r_done     <= 1'b0;
            r_state    <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed self-checking bench for prog_loader
module tb_prog_loader;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        mem_we;
  logic        mem_sel;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic        core_rst;
  logic        done;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;
  int n_writes = 0;
  int stall = 0;
  int we_cycles = 0;
  int rdy_bad = 0;

  logic [31:0] imem_m [0:4095];
  logic [31:0] dmem_m [0:4095];
  logic [7:0]  frame [$];

  prog_loader #(.ADDR_W(12)) dut (
    .CLK(CLK), .RST(RST),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .core_rst(core_rst), .done(done), .err(err)
  );

  always #5 CLK = ~CLK;

  assign mem_ready = (stall == 0);

  always @(posedge CLK) begin
    if (mem_we) begin
      we_cycles <= we_cycles + 1;
      if (rx_ready) rdy_bad <= rdy_bad + 1;
      if (stall > 0) stall <= stall - 1;
    end
    if (mem_we && mem_ready) begin
      n_writes <= n_writes + 1;
      if (mem_sel) dmem_m[mem_addr] <= mem_wdata;
      else         imem_m[mem_addr] <= mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 200) check("rx_ready_timeout", 32'd0, 32'd1);
    @(posedge CLK);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) send_byte(frame[i]);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  task automatic clear_models();
    for (int i = 0; i < 4096; i++) begin
      imem_m[i] = 32'd0;
      dmem_m[i] = 32'd0;
    end
  endtask

  initial begin
    clear_models();

    // reset state
    do_reset();
    check("rst_core_rst", core_rst, 1);
    check("rst_mem_we", mem_we, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_rx_ready", rx_ready, 1);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);

    // imem load, mem_ready tied high, with first-write latency check
    frame = '{8'h49, 8'h00, 8'h00, 8'h02, 8'h00,
              8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00, 8'hE2};
    send_range(0, 8);
    check("lat_mem_we", mem_we, 1);
    check("lat_rx_ready", rx_ready, 0);
    check("lat_addr", mem_addr, 0);
    check("lat_wdata", mem_wdata, 32'h00100513);
    check("lat_sel", mem_sel, 0);
    send_range(9, 13);
    check("iload_w0", imem_m[0], 32'h00100513);
    check("iload_w1", imem_m[1], 32'h00200593);
    check("iload_nwr", n_writes, 2);
    check("iload_err", err, 0);

    // same frame with 3 cycles of backpressure on the first write
    clear_models();
    we_cycles = 0;
    rdy_bad = 0;
    stall = 3;
    send_range(0, 13);
    check("bp_we_cycles", we_cycles, 5);
    check("bp_rdy_during_we", rdy_bad, 0);
    check("bp_w0", imem_m[0], 32'h00100513);
    check("bp_w1", imem_m[1], 32'h00200593);
    check("bp_nwr", n_writes, 4);
    check("bp_err", err, 0);

    // dmem load wrapping the address at 0xFFF
    frame = '{8'h44, 8'hFF, 8'h0F, 8'h02, 8'h00,
              8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h13};
    send_range(0, 13);
    check("wrap_fff", dmem_m[4095], 32'd1);
    check("wrap_000", dmem_m[0], 32'd2);
    check("wrap_sel", mem_sel, 1);
    check("wrap_err", err, 0);

    // cnt = 0 frame: header then checksum only
    frame = '{8'h49, 8'h05, 8'h00, 8'h00, 8'h00, 8'h05};
    send_range(0, 5);
    check("cnt0_nwr", n_writes, 6);
    check("cnt0_err", err, 0);
    check("cnt0_addr_hold", mem_addr, 12'h005);

    // go, byte ignored while running, halt
    send_byte(8'h47);
    check("go_core_rst", core_rst, 0);
    check("go_done", done, 1);
    send_byte(8'h49);
    check("run_ignore_done", done, 1);
    send_byte(8'h48);
    check("halt_core_rst", core_rst, 1);
    check("halt_done", done, 0);

    // bad checksum, then go must be ignored
    frame = '{8'h49, 8'h00, 8'h00, 8'h02, 8'h00,
              8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00, 8'hE3};
    send_range(0, 12);
    check("bad_err_before", err, 0);
    send_byte(frame[13]);
    check("bad_err_after", err, 1);
    send_byte(8'h47);
    check("bad_go_core_rst", core_rst, 1);
    check("bad_go_done", done, 0);

    // unknown command byte
    do_reset();
    check("rst_clears_err", err, 0);
    send_byte(8'h5A);
    check("unknown_err", err, 1);

    // reset after 3 data bytes aborts the frame
    do_reset();
    frame = '{8'h49, 8'h00, 8'h00, 8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC};
    send_range(0, 7);
    do_reset();
    repeat (3) @(posedge CLK);
    #1;
    check("abort_nwr", n_writes, 8);
    check("abort_mem_we", mem_we, 0);
    send_byte(8'h47);
    check("abort_then_go", done, 1);
    do_reset();
    check("rst_in_run_core_rst", core_rst, 1);
    check("rst_in_run_done", done, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
